// File: rtl/keypoint_reader_pkg.sv
// Shared types for the keypoint BRAM reader: packed keypoint record, FIFO entry and readout FSM states.
// Coordinate and address widths follow the octave image side length KP_DIMENSION.
package keypoint_reader_pkg;

  localparam int KP_DIMENSION = 4;

  function automatic int field_width(input int span);
    return (span > 1) ? $clog2(span) : 1;
  endfunction

  localparam int KP_CW = field_width(KP_DIMENSION);
  localparam int KP_AW = field_width(KP_DIMENSION * KP_DIMENSION);

  typedef struct packed {
    logic             polarity;
    logic [KP_CW-1:0] y;
    logic [KP_CW-1:0] x;
  } keypoint_t;

  typedef struct packed {
    logic      last;
    keypoint_t kp;
  } kp_entry_t;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} kp_rd_state_t;

endpackage

// File: rtl/keypoint_reader_if.sv
// Keypoint output stream; a beat transfers when kp_valid && kp_ready.
// Fields hold steady while kp_valid is high and kp_ready is low.
interface keypoint_reader_if
  import keypoint_reader_pkg::*;
();
  logic             kp_valid;
  logic             kp_ready;
  logic [KP_CW-1:0] kp_x;
  logic [KP_CW-1:0] kp_y;
  logic             kp_polarity;
  logic             kp_last;

  modport master (output kp_valid, kp_x, kp_y, kp_polarity, kp_last, input kp_ready);
  modport slave  (input kp_valid, kp_x, kp_y, kp_polarity, kp_last, output kp_ready);
endinterface

// File: rtl/keypoint_reader_fifo.sv
// Synchronous FIFO with fall-through head and occupancy count; zero-latency head, 1-cycle push-to-head.
// A push into a full FIFO is accepted only alongside a pop; otherwise it is an overflow.
module keypoint_reader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/keypoint_reader.sv
// Streams keypoint BRAM entries 0..num_keypts-1 as (x, y, polarity, last); first beat 3 cycles after start.
// Reads issue only while FIFO occupancy plus in-flight reads leaves room, so kp_ready backpressure never drops data.
module keypoint_reader
  import keypoint_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             start,
  input  logic [KP_AW:0]   num_keypts,
  output logic [KP_AW-1:0] key_read_addr,
  input  keypoint_t        key_data,
  output logic             busy,
  output logic             done,
  keypoint_reader_if.master kp
);
  localparam int CNT_W = KP_AW + 1;
  localparam int CRD_W = $clog2(FIFO_DEPTH + RD_LATENCY) + 1;
  localparam logic [CNT_W-1:0] MAX_KEYPTS = CNT_W'(KP_DIMENSION * KP_DIMENSION);

  kp_rd_state_t                state;
  kp_rd_state_t                state_nxt;
  logic [CNT_W-1:0]            total;
  logic [CNT_W-1:0]            issued;
  logic [CNT_W-1:0]            req_clamped;
  logic                        issue;
  logic                        issue_last;
  logic [RD_LATENCY-1:0]       rd_vld;
  logic [RD_LATENCY-1:0]       rd_last;
  logic [CRD_W-1:0]            in_flight;
  logic [CRD_W-1:0]            credits;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_empty;
  logic                        push;
  logic                        pop;
  kp_entry_t                   push_entry;
  kp_entry_t                   head;

  assign req_clamped   = (num_keypts > MAX_KEYPTS) ? MAX_KEYPTS : num_keypts;
  assign key_read_addr = issued[KP_AW-1:0];
  assign busy          = (state != IDLE);

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + CRD_W'(rd_vld[i]);
  end
  assign credits = CRD_W'(fifo_count) + in_flight;

  // Address 0 is already on the bus in IDLE, so the first read issues in the start cycle itself.
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (req_clamped == '0) begin
            state_nxt = DONE;
          end else begin
            issue      = 1'b1;
            issue_last = (req_clamped == CNT_W'(1));
            state_nxt  = issue_last ? DRAIN : READ;
          end
        end
      end
      READ: begin
        if (credits < CRD_W'(FIFO_DEPTH)) begin
          issue      = 1'b1;
          issue_last = (issued == total - CNT_W'(1));
          if (issue_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head.last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      total   <= '0;
      issued  <= '0;
      rd_vld  <= '0;
      rd_last <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) total <= req_clamped;
      if (state == DONE)  issued <= '0;
      else if (issue)     issued <= issued + CNT_W'(1);
      rd_vld[0]  <= issue;
      rd_last[0] <= issue && issue_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld[i]  <= rd_vld[i-1];
        rd_last[i] <= rd_last[i-1];
      end
    end
  end

  assign push            = rd_vld[RD_LATENCY-1];
  assign push_entry.last = rd_last[RD_LATENCY-1];
  assign push_entry.kp   = key_data;
  assign pop             = kp.kp_valid && kp.kp_ready;

  keypoint_reader_fifo #(
    .WIDTH($bits(kp_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_in),
    .push     (push),
    .push_dat (push_entry),
    .pop      (pop),
    .head_dat (head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign kp.kp_valid    = !fifo_empty;
  assign kp.kp_x        = head.kp.x;
  assign kp.kp_y        = head.kp.y;
  assign kp.kp_polarity = head.kp.polarity;
  assign kp.kp_last     = head.last;

  assert property (@(posedge clk) disable iff (!rst_in) done |=> !done);
  assert property (@(posedge clk) disable iff (!rst_in)
                   kp.kp_valid && !kp.kp_ready |=> kp.kp_valid && $stable(head));

endmodule
